trsq8_intc: RTL

Prioritising interrupt controller for the TRSQ8 core. Collects up to eight external interrupt sources, latches them as pending, masks them with a software-written enable register and drives the core's single `irq_ip` line. Sits on the 8-bit peripheral bus as a register-mapped slave. Runs a three-state acknowledge/service handshake so that only one source is in service at a time.

---
 rtl/trsq8_intc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/trsq8_intc.sv
// trsq8_intc: prioritising interrupt controller for the TRSQ8 core.
// Latches up to N_SRC sources as pending, masks them with IE and raises
// irq_op for one winner at a time through an IDLE/ASSERT/SERVICE handshake.
// Optional feature macro: TRSQ8_INTC_ROUNDROBIN_EN selects rotating priority
// (search starts after the last acknowledged id); undefined gives fixed
// priority where the lowest enabled pending index wins.
//
// Bus handshake: a transfer happens in any cycle where wr_en or rd_en is high
// and addr hits BASE_ADDR..BASE_ADDR+4; there is no wait state, read data is
// combinational in the same cycle, and write/read side effects land on the
// closing clk_ip edge.
module trsq8_intc #(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic             clk_ip,
    input  logic             reset,
    input  logic [7:0]       addr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [N_SRC-1:0] src_ip,
    output logic             irq_op,
    output logic [N_SRC-1:0] active_op
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       id_q, id_d, win_id;
    logic             win_vld;
    logic [N_SRC-1:0] ie_q, ie_d, ip_q, ip_d, mode_q, src_prev_q;
    logic [N_SRC-1:0] ip_set, ip_clr, elig, cand, id_mask;
    logic [7:0]       off, ie_ext, ip_ext, mode_ext;
    logic             sel_ie, sel_ip, sel_vec, sel_eoi, sel_mode;
    logic             vec_ack, eoi_wr;

    // Register decode relative to the block base address.
    assign off      = addr - BASE_ADDR;
    assign sel_ie   = (off == 8'd0);
    assign sel_ip   = (off == 8'd1);
    assign sel_vec  = (off == 8'd2);
    assign sel_eoi  = (off == 8'd3);
    assign sel_mode = (off == 8'd4);

    assign vec_ack = rd_en && sel_vec && (state_q == S_ASSERT);
    assign eoi_wr  = wr_en && sel_eoi && (state_q == S_SERVICE);

    // One-hot decode of the latched winner id.
    always_comb begin
        id_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_mask[i] = (id_q == 3'(i));
        end
    end

    // Next IE and IP: level sources set every cycle, edge sources on 0->1;
    // a coincident set beats a W1C or acknowledge clear.
    always_comb begin
        ie_d   = (wr_en && sel_ie) ? data_in[N_SRC-1:0] : ie_q;
        ip_set = src_ip & ~(mode_q & src_prev_q);
        ip_clr = ((wr_en && sel_ip) ? data_in[N_SRC-1:0] : '0)
               | (vec_ack ? id_mask : '0);
        ip_d   = (ip_q & ~ip_clr) | ip_set;
    end

    assign elig = ip_q & ie_q;

`ifdef TRSQ8_INTC_ROUNDROBIN_EN
    logic [2:0]       ptr_q;
    logic [N_SRC-1:0] ge_mask;

    // Rotating priority: prefer candidates at or above the pointer, else wrap.
    always_comb begin
        ge_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ge_mask[i] = (3'(i) >= ptr_q);
        end
        cand = (|(elig & ge_mask)) ? (elig & ge_mask) : elig;
    end

    // Pointer moves past each acknowledged id.
    always_ff @(posedge clk_ip) begin
        if (reset) begin
            ptr_q <= 3'd0;
        end else if (vec_ack) begin
            ptr_q <= (id_q == 3'(N_SRC - 1)) ? 3'd0 : id_q + 3'd1;
        end
    end
`else
    assign cand = elig;
`endif

    // Lowest set index among the candidates is the winner.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_vld = 1'b1;
                win_id  = 3'(i);
            end
        end
    end

    // Handshake FSM: the id is chosen only in IDLE and frozen in ASSERT.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_ASSERT;
                    id_d    = win_id;
                end
            end
            S_ASSERT: begin
                if (vec_ack) begin
                    state_d = S_SERVICE;
                end else if (!(|(ip_d & ie_d & id_mask))) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (eoi_wr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, register file and registered outputs.
    always_ff @(posedge clk_ip) begin
        if (reset) begin
            state_q    <= S_IDLE;
            id_q       <= 3'd0;
            ie_q       <= '0;
            ip_q       <= '0;
            mode_q     <= '0;
            src_prev_q <= '0;
            irq_op     <= 1'b0;
            active_op  <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            src_prev_q <= src_ip;
            irq_op     <= (state_d == S_ASSERT);
            if (wr_en && sel_mode) begin
                mode_q <= data_in[N_SRC-1:0];
            end
            if (vec_ack) begin
                active_op <= id_mask;
            end else if (eoi_wr) begin
                active_op <= '0;
            end
        end
    end

    // Combinational read mux; unused source bits read as zero.
    always_comb begin
        ie_ext               = 8'h00;
        ip_ext               = 8'h00;
        mode_ext             = 8'h00;
        ie_ext[N_SRC-1:0]    = ie_q;
        ip_ext[N_SRC-1:0]    = ip_q;
        mode_ext[N_SRC-1:0]  = mode_q;
        data_out             = 8'h00;
        if (rd_en) begin
            if (sel_ie) begin
                data_out = ie_ext;
            end else if (sel_ip) begin
                data_out = ip_ext;
            end else if (sel_vec && (state_q == S_ASSERT)) begin
                data_out = {1'b1, 4'b0000, id_q};
            end else if (sel_mode) begin
                data_out = mode_ext;
            end
        end
    end

endmodule
